mem_bus_responder: RTL and testbench

Cycle-accurate slave model for one core memory port (instruction or data) of `frv_core`. It sits directly upstream of the core's `imem_*`/`dmem_*` inputs in simulation and formal harnesses. It replaces free `$anyseq` responses with a protocol-correct req/gnt responder backed by a small word array. Two instances, one per port, drive the core's `*_gnt`, `*_error` and `*_rdata`.

---
 rtl/mem_bus_responder.sv | 190 +++++++++++++++++++
 tb/tb_mem_bus_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Memory port responder: req/gnt slave backed by a word array, answering one request per grant.
// Latency: gnt registered N+1 cycles after req first seen (N = STALL, or LFSR-derived with MEM_RESP_RANDOM_STALL_EN).
// Backpressure: requester holds req until gnt; at least one idle cycle separates grants.
module mem_bus_responder #(
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  parameter int          STALL     = 2,
  parameter int          MAX_STALL = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_error,
  output logic [31:0] mem_rdata,
  output logic        proto_err
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0 ||
      STALL < 0 || STALL > 15 || MAX_STALL < 0 || MAX_STALL > 15) begin : g_param_check
    $error("mem_bus_responder: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            gnt_q, gnt_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            proto_q, proto_d;
  logic [68:0]     hold_q, hold_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_idx_q, wr_idx_d;
  logic [3:0]      wr_strb_q, wr_strb_d;
  logic [31:0]     wr_data_q, wr_data_d;

  logic [31:0]     mem_q [DEPTH];

  logic [68:0]     req_vec;
  logic [31:0]     off;
  logic            in_range;
  logic [AW-1:0]   idx;
  logic [3:0]      n_stall;
  logic            go_grant;

  assign req_vec = {mem_wen, mem_strb, mem_wdata, mem_addr};

`ifdef MEM_RESP_RANDOM_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4, free-running every cycle
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // LFSR state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  // grant delay drawn from the low LFSR nibble, folded into 0..MAX_STALL
  always_comb n_stall = 4'({28'd0, lfsr_q[3:0]} % (MAX_STALL + 1));
`else
  // fixed grant delay
  always_comb n_stall = 4'(STALL);
`endif

  // address decode; offset form avoids overflow when BASE sits near the top of the map
  always_comb begin
    off      = mem_addr - BASE;
    in_range = (mem_addr >= BASE) && (off < 32'(4 * DEPTH)) && (mem_addr[1:0] == 2'b00);
    idx      = off[AW+1:2];
  end

  // next state, stall counting, protocol checking and response formation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = 32'd0;
    proto_d   = proto_q;
    hold_d    = hold_q;
    wr_en_d   = wr_en_q;
    wr_idx_d  = wr_idx_q;
    wr_strb_d = wr_strb_q;
    wr_data_d = wr_data_q;
    go_grant  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          hold_d = req_vec;
          if (n_stall == 4'd0) begin
            go_grant = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = n_stall;
          end
        end
      end
      WAIT: begin
        if (!mem_req) begin
          // request withdrawn before grant: abandon it
          proto_d = 1'b1;
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          // attributes must be stable; flag a change but carry on with the live values
          if (req_vec != hold_q) proto_d = 1'b1;
          hold_d = req_vec;
          if (cnt_q == 4'd1) begin
            go_grant = 1'b1;
            cnt_d    = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      GRANT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // response and write intent are captured on the edge that enters GRANT
    if (go_grant) begin
      state_d   = GRANT;
      gnt_d     = 1'b1;
      err_d     = !in_range;
      rdata_d   = (!mem_wen && in_range) ? mem_q[idx] : 32'd0;
      wr_en_d   = mem_wen && in_range;
      wr_idx_d  = idx;
      wr_strb_d = mem_strb;
      wr_data_d = mem_wdata;
    end
  end

  // control and response registers; reset aborts any transaction in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      gnt_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      proto_q   <= 1'b0;
      hold_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_strb_q <= 4'd0;
      wr_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      proto_q   <= proto_d;
      hold_q    <= hold_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_strb_q <= wr_strb_d;
      wr_data_q <= wr_data_d;
    end
  end

  // commit granted writes byte by byte at the end of the GRANT cycle
  always_ff @(posedge clock) begin
    if (state_q == GRANT && wr_en_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb_q[i]) mem_q[wr_idx_q][8*i +: 8] <= wr_data_q[8*i +: 8];
      end
    end
  end

  assign mem_gnt   = gnt_q;
  assign mem_error = err_q;
  assign mem_rdata = rdata_q;
  assign proto_err = proto_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed cases plus randomized traffic against a word-array model.
// The compare process checks gnt/proto_err every cycle and response fields on each grant.
// Build with MEM_RESP_RANDOM_STALL_EN to exercise random stall latency coverage instead of fixed latency.
module tb_mem_bus_responder;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam int          DEPTH     = 256;
  localparam int          STALL     = 2;
  localparam int          MAX_STALL = 7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req, wen, req3;
  logic [3:0]  strb;
  logic [31:0] wdata, addr;
  logic        gnt, err, perr, gnt3, err3, perr3;
  logic [31:0] rdata, rdata3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit exp_p3 = 1'b0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] mdl [DEPTH];

  mem_bus_responder #(.BASE(BASE), .DEPTH(DEPTH), .STALL(STALL), .MAX_STALL(MAX_STALL)) dut (
    .clock(clock), .reset(reset), .mem_req(req), .mem_wen(wen), .mem_strb(strb),
    .mem_wdata(wdata), .mem_addr(addr), .mem_gnt(gnt), .mem_error(err),
    .mem_rdata(rdata), .proto_err(perr)
  );

  mem_bus_responder #(.BASE(BASE), .DEPTH(DEPTH), .STALL(3), .MAX_STALL(MAX_STALL)) dut3 (
    .clock(clock), .reset(reset), .mem_req(req3), .mem_wen(wen), .mem_strb(strb),
    .mem_wdata(wdata), .mem_addr(addr), .mem_gnt(gnt3), .mem_error(err3),
    .mem_rdata(rdata3), .proto_err(perr3)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint ua, ub;
    ua = a;
    ub = BASE;
    return (ua >= ub) && (ua < ub + 4 * DEPTH) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 99);
    if (r < 80)      return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    else if (r < 85) return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
    else if (r < 90) return BASE - 32'(4 * $urandom_range(1, 4));
    else if (r < 95) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
    else             return $urandom;
  endfunction

  // Compare process: every cycle, gnt only where the model expects one; response fields on grants
  always @(negedge clock) begin
    if (expq.size() > 0 && ((expq[0].cyc == cyc) || (expq[0].cyc < 0 && gnt === 1'b1))) begin
      check("gnt", {31'd0, gnt}, 32'd1);
      check("error", {31'd0, err}, {31'd0, expq[0].err});
      check("rdata", rdata, expq[0].rdata);
      void'(expq.pop_front());
    end else begin
      check("gnt_idle", {31'd0, gnt}, 32'd0);
    end
    check("proto_err", {31'd0, perr}, 32'd0);
    check("gnt3", {31'd0, gnt3}, 32'd0);
    check("proto_err3", {31'd0, perr3}, {31'd0, exp_p3});
  end

  // Issue one request (called #1 after a rising edge), hold it until gnt, return one cycle later
  task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic er);
    exp_t e;
    bit   ok;
    bit   lat_ok;
    int   idx;
    int   t;
    ok = in_rng(a);
    idx = ok ? int'((a - BASE) >> 2) : 0;
    e.err = !ok;
    e.rdata = (!w && ok) ? mdl[idx] : 32'd0;
    if (w && ok) begin
      for (int i = 0; i < 4; i++) if (s[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
    end
    t = cyc;
`ifdef MEM_RESP_RANDOM_STALL_EN
    e.cyc = -1;
`else
    e.cyc = t + STALL + 1;
`endif
    expq.push_back(e);
    req = 1'b1; wen = w; addr = a; strb = s; wdata = d;
    lat = -1; rd = 32'd0; er = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (gnt === 1'b1) begin
        lat = cyc - t;
        rd = rdata;
        er = err;
        break;
      end
    end
`ifdef MEM_RESP_RANDOM_STALL_EN
    lat_ok = (lat >= 1) && (lat <= MAX_STALL + 1);
`else
    lat_ok = (lat == STALL + 1);
`endif
    checks++;
    if (!lat_ok) begin
      errors++;
      $display("FAIL latency: got %0d (-1 = no grant) for addr %h", lat, a);
    end
    @(posedge clock); #1;
  endtask

  task automatic idle();
    req = 1'b0;
    @(posedge clock); #1;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  bit          seen[16];

  initial begin
    req = 1'b0; req3 = 1'b0; wen = 1'b0; strb = 4'd0; wdata = 32'd0; addr = BASE;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_gnt", {31'd0, gnt}, 32'd0);
    check("rst_error", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_proto", {31'd0, perr}, 32'd0);
    check("rst_rdata3", rdata3, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // fill every word so later reads never see uninitialised contents
    for (int i = 0; i < DEPTH; i++) issue(1'b1, BASE + 32'(4 * i), 4'hF, $urandom, lat, rd, er);
    idle();

    // read of a preloaded word: latency STALL+1, data as written
    issue(1'b1, BASE + 32'd8, 4'hF, 32'hDEAD_BEEF, lat, rd, er);
    idle(); idle();
    issue(1'b0, BASE + 32'd8, 4'h0, 32'd0, lat, rd, er);
`ifndef MEM_RESP_RANDOM_STALL_EN
    check("t1_latency", 32'(lat), 32'd3);
`endif
    check("t1_rdata", rd, 32'hDEAD_BEEF);
    check("t1_error", {31'd0, er}, 32'd0);
    idle();

    // partial-strobe write merge, read immediately after the write grant
    issue(1'b1, BASE + 32'd20, 4'hF, 32'd0, lat, rd, er);
    issue(1'b1, BASE + 32'd20, 4'b0101, 32'h1122_3344, lat, rd, er);
    check("t2_wr_rdata", rd, 32'd0);
    issue(1'b0, BASE + 32'd20, 4'h0, 32'd0, lat, rd, er);
    check("t2_rdata", rd, 32'h0022_0044);
    issue(1'b1, BASE + 32'd20, 4'h0, 32'hFFFF_FFFF, lat, rd, er);
    issue(1'b0, BASE + 32'd20, 4'h0, 32'd0, lat, rd, er);
    check("t2_strb0_noop", rd, 32'h0022_0044);
    idle();

    // out-of-range and misaligned accesses error out and leave the array alone
    issue(1'b1, BASE, 4'hF, 32'hA5A5_5A5A, lat, rd, er);
    issue(1'b0, BASE + 32'(4 * DEPTH), 4'h0, 32'd0, lat, rd, er);
    check("t3_oob_error", {31'd0, er}, 32'd1);
    check("t3_oob_rdata", rd, 32'd0);
    issue(1'b0, BASE + 32'd2, 4'h0, 32'd0, lat, rd, er);
    check("t3_mis_error", {31'd0, er}, 32'd1);
    check("t3_mis_rdata", rd, 32'd0);
    issue(1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'h1234_5678, lat, rd, er);
    check("t3_oob_wr_error", {31'd0, er}, 32'd1);
    issue(1'b1, BASE + 32'd2, 4'hF, 32'h8765_4321, lat, rd, er);
    issue(1'b1, BASE - 32'd4, 4'hF, 32'h0BAD_F00D, lat, rd, er);
    check("t3_low_wr_error", {31'd0, er}, 32'd1);
    issue(1'b0, BASE, 4'h0, 32'd0, lat, rd, er);
    check("t3_unchanged", rd, 32'hA5A5_5A5A);
    idle();

`ifndef MEM_RESP_RANDOM_STALL_EN
    // dropped request on the STALL=3 instance: no grant, sticky proto_err
    req3 = 1'b1;
    @(posedge clock); #1;
    req3 = 1'b0;
    @(posedge clock); #1;
    exp_p3 = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("t4_proto_held", {31'd0, perr3}, 32'd1);

    // reset in WAIT of a write: aborted, not committed, next request normal
    issue(1'b1, BASE, 4'hF, 32'd0, lat, rd, er);
    idle();
    req = 1'b1; wen = 1'b1; addr = BASE; strb = 4'hF; wdata = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    reset = 1'b1;
    exp_p3 = 1'b0;
    req = 1'b0;
    #1;
    check("t5_gnt", {31'd0, gnt}, 32'd0);
    check("t5_error", {31'd0, err}, 32'd0);
    check("t5_rdata", rdata, 32'd0);
    check("t5_proto3", {31'd0, perr3}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    issue(1'b0, BASE, 4'h0, 32'd0, lat, rd, er);
    check("t5_not_committed", rd, 32'd0);
    check("t5_latency", 32'(lat), 32'd3);
    idle();
`endif

    // randomized mixed traffic with occasional gaps
    for (int n = 0; n < 400; n++) begin
      issue(1'($urandom_range(0, 1)), pick_addr(), 4'($urandom), $urandom, lat, rd, er);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) idle();
      end
    end
    idle();

    // back-to-back reads, latency histogram
    for (int n = 0; n < 1000; n++) begin
      issue(1'b0, BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 4'h0, 32'd0, lat, rd, er);
      if (lat >= 0 && lat < 16) seen[lat] = 1'b1;
    end
    idle();
`ifdef MEM_RESP_RANDOM_STALL_EN
    for (int l = 1; l <= MAX_STALL + 1; l++) check("latency_seen", {31'd0, seen[l]}, 32'd1);
`else
    check("latency_seen", {31'd0, seen[STALL + 1]}, 32'd1);
`endif

    repeat (3) idle();
    check("queue_drained", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
